// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared sizes, source indices and pointer helper for the CDB arbiter
package cdb_arbiter_pkg;
   localparam int N_SRC    = 4;
   localparam int DATA_W   = 32;
   localparam int LABEL_W  = 4;
   localparam int MAX_WAIT = 15;
   localparam int PTR_W    = $clog2(N_SRC);
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   localparam logic [LABEL_W-1:0] NO_LABEL = '0;

   typedef enum logic [PTR_W-1:0] {
      SRC_ALU = 2'd0,
      SRC_MUL = 2'd1,
      SRC_DIV = 2'd2,
      SRC_LS  = 2'd3
   } src_e;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
      return (int'(idx) == N_SRC - 1) ? '0 : idx + PTR_W'(1);
   endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - require/requireAC request side and registered broadcast side of the CDB
interface cdb_arbiter_if;
   import cdb_arbiter_pkg::*;

   logic [N_SRC-1:0]         require;
   logic [N_SRC*DATA_W-1:0]  data_in;
   logic [N_SRC*LABEL_W-1:0] label_in;
   logic [N_SRC-1:0]         requireAC;
   logic                     BCEN;
   logic [DATA_W-1:0]        BCdata;
   logic [LABEL_W-1:0]       BClabel;
   logic [N_SRC-1:0]         starve_err;

   modport master (
      output require, data_in, label_in,
      input  requireAC, BCEN, BCdata, BClabel, starve_err
   );

   modport slave (
      input  require, data_in, label_in,
      output requireAC, BCEN, BCdata, BClabel, starve_err
   );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - combinational round-robin one-hot picker starting at ptr
module cdb_arbiter_rr_pick
   import cdb_arbiter_pkg::*;
(
   input  logic [N_SRC-1:0] i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N_SRC-1:0] o_grant,
   output logic [PTR_W-1:0] o_grant_idx
);
   logic             w_found;
   logic [PTR_W-1:0] w_idx;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      w_found     = 1'b0;
      w_idx       = '0;
      for (int k = 0; k < N_SRC; k++) begin
         w_idx = PTR_W'((int'(i_ptr) + k) % N_SRC);
         if (!w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = w_idx;
         end
      end
   end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB grant, registered broadcast and per-unit starvation watch
module cdb_arbiter
   import cdb_arbiter_pkg::*;
(
   input logic          clk,
   input logic          nRST,
   cdb_arbiter_if.slave bus
);
   logic [PTR_W-1:0]   r_ptr;
   logic               r_bcen;
   logic [DATA_W-1:0]  r_bcdata;
   logic [LABEL_W-1:0] r_bclabel;
   logic [CNT_W-1:0]   r_wait [N_SRC];
   logic [N_SRC-1:0]   r_starve;

   logic [N_SRC-1:0]   w_pick;
   logic [N_SRC-1:0]   w_grant;
   logic [PTR_W-1:0]   w_idx;
   logic               w_any;
   logic [CNT_W-1:0]   w_wait_nxt [N_SRC];

   cdb_arbiter_rr_pick u_pick (
      .i_req       (bus.require),
      .i_ptr       (r_ptr),
      .o_grant     (w_pick),
      .o_grant_idx (w_idx)
   );

   // Everything downstream keys off w_grant, so a grant seen during reset is void everywhere.
   assign w_grant = nRST ? '0 : w_pick;
   assign w_any   = |w_grant;

   assign bus.requireAC  = w_grant;
   assign bus.BCEN       = r_bcen;
   assign bus.BCdata     = r_bcdata;
   assign bus.BClabel    = r_bclabel;
   assign bus.starve_err = r_starve;

   always_ff @(posedge clk) begin
      if (nRST) begin
         r_ptr     <= '0;
         r_bcen    <= 1'b0;
         r_bcdata  <= '0;
         r_bclabel <= NO_LABEL;
      end else begin
         r_bcen <= w_any;
         if (w_any) begin
            r_bcdata  <= bus.data_in[w_idx*DATA_W +: DATA_W];
            r_bclabel <= bus.label_in[w_idx*LABEL_W +: LABEL_W];
            r_ptr     <= next_ptr(w_idx);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         w_wait_nxt[i] = '0;
         if (bus.require[i] && !w_grant[i])
            w_wait_nxt[i] = (r_wait[i] == CNT_W'(MAX_WAIT)) ? r_wait[i] : r_wait[i] + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (nRST) begin
         r_starve <= '0;
         for (int i = 0; i < N_SRC; i++) r_wait[i] <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            r_wait[i] <= w_wait_nxt[i];
            if (w_wait_nxt[i] == CNT_W'(MAX_WAIT)) r_starve[i] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter with a broadcast scoreboard
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   typedef struct {
      bit          en;
      logic [31:0] d;
      logic [3:0]  l;
   } bc_t;

   logic clk = 1'b0;
   logic nRST;
   int   checks = 0;
   int   errors = 0;
   int   m_ptr  = 0;
   logic [3:0] m_starve = '0;
   bc_t  q[$];

   always #5 clk = ~clk;

   cdb_arbiter_if bus ();

   cdb_arbiter dut (
      .clk  (clk),
      .nRST (nRST),
      .bus  (bus)
   );

   task automatic set_unit(input int i, input logic [31:0] d, input logic [3:0] l);
      bus.data_in[i*32 +: 32] = d;
      bus.label_in[i*4 +: 4]  = l;
   endtask

   // One clock: drive require, predict the grant, then check the broadcast it produces.
   task automatic cycle(input logic [3:0] req);
      logic [3:0] exp_g;
      bc_t e;
      bc_t got;
      int  u;
      int  gi;
      bus.require = req;
      @(negedge clk);
      exp_g = '0;
      gi    = -1;
      e.en  = 1'b0;
      e.d   = '0;
      e.l   = '0;
      if (!nRST) begin
         for (int k = 0; k < 4; k++) begin
            u = (m_ptr + k) % 4;
            if (gi < 0 && req[u]) gi = u;
         end
      end
      if (gi >= 0) begin
         exp_g[gi] = 1'b1;
         e.en  = 1'b1;
         e.d   = bus.data_in[gi*32 +: 32];
         e.l   = bus.label_in[gi*4 +: 4];
         m_ptr = (gi + 1) % 4;
      end
      if (nRST) m_ptr = 0;
      checks++;
      if (bus.requireAC !== exp_g) begin
         errors++;
         $display("FAIL requireAC req=%b got=%b exp=%b", req, bus.requireAC, exp_g);
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      got = q.pop_front();
      checks++;
      if (bus.BCEN !== got.en) begin
         errors++;
         $display("FAIL BCEN got=%b exp=%b", bus.BCEN, got.en);
      end
      if (got.en) begin
         checks++;
         if (bus.BCdata !== got.d || bus.BClabel !== got.l) begin
            errors++;
            $display("FAIL bcast got=%h/%h exp=%h/%h", bus.BCdata, bus.BClabel, got.d, got.l);
         end
      end
      checks++;
      if (bus.starve_err !== m_starve) begin
         errors++;
         $display("FAIL starve_err got=%b exp=%b", bus.starve_err, m_starve);
      end
   endtask

   task automatic do_reset();
      nRST = 1'b1;
      bus.require = '0;
      repeat (2) @(posedge clk);
      #1;
      nRST = 1'b0;
      m_ptr = 0;
      m_starve = '0;
      q.delete();
   endtask

   task automatic test_reset();
      nRST = 1'b1;
      bus.require  = 4'b1111;
      bus.data_in  = '1;
      bus.label_in = '1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.requireAC !== 4'b0000) begin
         errors++;
         $display("FAIL reset_requireAC got=%b exp=0000", bus.requireAC);
      end
      checks++;
      if (bus.BCEN !== 1'b0 || bus.BCdata !== 32'h0 || bus.BClabel !== 4'h0) begin
         errors++;
         $display("FAIL reset_bcast got=%b/%h/%h exp=0/0/0", bus.BCEN, bus.BCdata, bus.BClabel);
      end
      checks++;
      if (bus.starve_err !== 4'b0000) begin
         errors++;
         $display("FAIL reset_starve got=%b exp=0000", bus.starve_err);
      end
      bus.require = '0;
      nRST = 1'b0;
      m_ptr = 0;
   endtask

   task automatic test_single();
      set_unit(0, 32'h5, 4'h1);
      cycle(4'b0001);
      cycle(4'b0000);
   endtask

   task automatic test_all_request();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < 4; i++) set_unit(i, $urandom, 4'(i + 1));
         cycle(4'b1111);
      end
      cycle(4'b0000);
   endtask

   task automatic test_wrap();
      set_unit(2, 32'hDD00_0002, 4'h7);
      set_unit(3, 32'hCC00_0003, 4'h9);
      set_unit(0, 32'hAA00_0000, 4'h3);
      cycle(4'b0100);
      cycle(4'b1001);
      cycle(4'b1001);
      cycle(4'b0000);
   endtask

   task automatic test_single_release();
      set_unit(2, 32'h1234_5678, 4'hB);
      cycle(4'b0100);
      cycle(4'b0000);
      cycle(4'b0000);
   endtask

   task automatic test_tag_zero();
      set_unit(1, 32'hFEED_0001, 4'h0);
      cycle(4'b0010);
      cycle(4'b0000);
   endtask

   task automatic test_reset_mid_handshake();
      set_unit(1, 32'h0000_0B0B, 4'h2);
      set_unit(3, 32'h0000_0D0D, 4'h4);
      cycle(4'b0010);
      nRST = 1'b1;
      cycle(4'b0010);
      nRST = 1'b0;
      cycle(4'b1010);
      cycle(4'b0000);
   endtask

   task automatic test_starvation();
      bus.require = 4'b0010;
      force dut.w_grant = 4'b0000;
      repeat (MAX_WAIT - 1) @(posedge clk);
      #1;
      checks++;
      if (bus.starve_err !== 4'b0000) begin
         errors++;
         $display("FAIL starve_early got=%b exp=0000", bus.starve_err);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.starve_err !== 4'b0010) begin
         errors++;
         $display("FAIL starve_set got=%b exp=0010", bus.starve_err);
      end
      bus.require = 4'b0000;
      @(posedge clk);
      #1;
      release dut.w_grant;
      m_starve = 4'b0010;
      set_unit(1, 32'h0000_1111, 4'h5);
      cycle(4'b0010);
      cycle(4'b0000);
      do_reset();
      checks++;
      if (bus.starve_err !== 4'b0000) begin
         errors++;
         $display("FAIL starve_clear got=%b exp=0000", bus.starve_err);
      end
   endtask

   initial begin
      bus.require  = '0;
      bus.data_in  = '0;
      bus.label_in = '0;
      nRST = 1'b1;
      test_reset();
      test_single();
      test_all_request();
      test_wrap();
      test_single_release();
      test_tag_zero();
      test_reset_mid_handshake();
      test_starvation();
      test_single();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
